// File: rtl/vcpu_memdump.sv
// Bus-mastering readback engine: reads a byte range from vcpu_mem and streams
// each byte with its address over valid/ready, keeping a running 8-bit checksum.
module vcpu_memdump (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] startAddress,
  input  logic [15:0] length,
  output logic        busy,
  output logic        memReq,
  input  logic        memGrant,
  output logic        memClk,
  output logic        memWE,
  output logic [15:0] memAddress,
  output logic [7:0]  memData,
  input  logic [7:0]  memQ,
  output logic        outValid,
  input  logic        outReady,
  output logic [7:0]  outData,
  output logic [15:0] outAddress,
  output logic        done,
  output logic [7:0]  checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SETUP,
    S_STROBE,
    S_SEND,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_addr;
  logic [15:0] r_remain;
  logic [15:0] r_outAddress;
  logic [7:0]  r_outData;
  logic [7:0]  r_checksum;
  logic        r_memClk;
  logic        w_accept;
  logic        w_capture;
  logic        w_handshake;

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = (length == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (memGrant) w_next = S_SETUP;
      end
      S_SETUP: begin
        w_next = memGrant ? S_STROBE : S_REQ;
      end
      S_STROBE: begin
        // losing the grant here discards the read; the address is retried
        if (!memGrant) begin
          w_next = S_REQ;
        end else begin
          w_capture = 1'b1;
          w_next    = S_SEND;
        end
      end
      S_SEND: begin
        if (outReady) begin
          w_handshake = 1'b1;
          w_next      = (r_remain == 16'd1) ? S_DONE : S_SETUP;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_remain     <= '0;
      r_outAddress <= '0;
      r_outData    <= '0;
      r_checksum   <= '0;
      r_memClk     <= 1'b0;
    end else begin
      r_state  <= w_next;
      // strobe is registered so it is high for exactly the STROBE cycle
      r_memClk <= (w_next == S_STROBE);
      if (w_accept) begin
        r_addr     <= startAddress;
        r_remain   <= length;
        r_checksum <= '0;
      end
      if (w_capture) begin
        r_outData    <= memQ;
        r_outAddress <= r_addr;
        r_checksum   <= r_checksum + memQ;
      end
      if (w_handshake) begin
        r_addr   <= r_addr + 16'd1;
        r_remain <= r_remain - 16'd1;
      end
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign memReq     = (r_state == S_REQ) || (r_state == S_SETUP) ||
                      (r_state == S_STROBE) || (r_state == S_SEND);
  assign memClk     = r_memClk;
  assign memWE      = 1'b0;
  assign memAddress = r_addr;
  assign memData    = '0;
  assign outValid   = (r_state == S_SEND);
  assign outData    = r_outData;
  assign outAddress = r_outAddress;
  assign done       = (r_state == S_DONE);
  assign checksum   = r_checksum;

endmodule
